// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between IFU and LSU for one memory port, with a grant-to-response watchdog.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; default is fixed LSU priority.
// state | meaning: S_IDLE = waiting for a request; S_REQ = presenting request; S_RESP = waiting for response
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,
    output logic                busy
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              owner_lsu;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  wd_cnt;

    logic grant_lsu, grant_ifu, accept, resp_done, wd_fire, wd_hit;

    assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_lsu = 1'b0;
        grant_ifu = 1'b0;
        accept    = 1'b0;
        resp_done = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                // owner_lsu holds the last grant, so contention goes to the other side
                if (lsu_req_valid && ifu_req_valid) begin
                    grant_lsu = !owner_lsu;
                    grant_ifu = owner_lsu;
                end else begin
                    grant_lsu = lsu_req_valid;
                    grant_ifu = ifu_req_valid;
                end
`else
                grant_lsu = lsu_req_valid;
                grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
                if (grant_lsu || grant_ifu) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (wd_hit) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // a response arriving on the expiry cycle beats the watchdog
                if (mem_resp_valid) begin
                    resp_done = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wd_hit) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ifu_req_ready = grant_ifu && rst;
    assign lsu_req_ready = grant_lsu && rst;
    assign mem_req_valid = (state == S_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_lsu      <= 1'b0;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            wd_cnt         <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if (accept) begin
                owner_lsu <= grant_lsu;
                wd_cnt    <= '0;
                if (grant_lsu) begin
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end else if (state != S_IDLE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (resp_done || wd_fire) begin
                if (owner_lsu) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= (resp_done && !wen_q) ? mem_rdata : '0;
                    lsu_resp_err   <= resp_done ? mem_resp_err : 1'b1;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= resp_done ? mem_rdata : '0;
                    ifu_resp_err   <= resp_done ? mem_resp_err : 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // memory responder knobs
    bit          mem_mute = 0;
    bit          spur     = 0;
    bit          mem_err_knob = 0;
    logic [31:0] mem_data = 32'h0;
    bit          r_hs, r_err;
    logic [31:0] r_data;

    // model state
    bit          m_busy, m_owner_lsu, m_last_lsu, m_acc;
    int          m_age;
    logic [31:0] m_addr, m_wdata, m_irdata, m_lrdata;
    logic        m_wen, m_irv, m_ierr, m_lrv, m_lerr;
    logic [3:0]  m_wmask;
    bit          pick_l, any_req, e_iready, e_lready;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit lsu, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (lsu ? lsu_resp_valid : ifu_resp_valid) begin
                at = cyc;
                break;
            end
        end
        chk(lsu ? "lsu_resp_arrives" : "ifu_resp_arrives", 32'(at >= 0), 32'd1);
    endtask

    // memory: answers one cycle after each accepted request unless muted; spur injects a stray response
    initial begin
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            r_hs   = rst && ((mem_req_valid && mem_req_ready && !mem_mute) || spur);
            r_data = mem_data;
            r_err  = mem_err_knob;
            @(posedge clk);
            #1;
            mem_resp_valid = r_hs;
            mem_rdata      = r_hs ? r_data : 32'h0;
            mem_resp_err   = r_hs ? r_err : 1'b0;
        end
    end

    task automatic model_reset();
        m_busy = 0; m_owner_lsu = 0; m_last_lsu = 0; m_acc = 0; m_age = 0;
        m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
        m_irv = 0; m_irdata = '0; m_ierr = 0;
        m_lrv = 0; m_lrdata = '0; m_lerr = 0;
    endtask

    task automatic deliver(input logic err, input logic [31:0] data);
        if (m_owner_lsu) begin
            m_lrv = 1; m_lrdata = data; m_lerr = err;
        end else begin
            m_irv = 1; m_irdata = data; m_ierr = err;
        end
        m_busy = 0;
    endtask

    task automatic compare_all();
        chk("ifu_req_ready",  32'(ifu_req_ready),  32'(e_iready));
        chk("lsu_req_ready",  32'(lsu_req_ready),  32'(e_lready));
        chk("mem_req_valid",  32'(mem_req_valid),  32'(m_busy && !m_acc));
        chk("busy",           32'(busy),           32'(m_busy));
        chk("mem_addr",       mem_addr,            m_addr);
        chk("mem_wen",        32'(mem_wen),        32'(m_wen));
        chk("mem_wdata",      mem_wdata,           m_wdata);
        chk("mem_wmask",      32'(mem_wmask),      32'(m_wmask));
        chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_irv));
        chk("ifu_rdata",      ifu_rdata,           m_irdata);
        chk("ifu_resp_err",   32'(ifu_resp_err),   32'(m_ierr));
        chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_lrv));
        chk("lsu_rdata",      lsu_rdata,           m_lrdata);
        chk("lsu_resp_err",   32'(lsu_resp_err),   32'(m_lerr));
    endtask

    // Model: a transaction is granted, gets TO busy cycles at most, and completes on the
    // first response after the memory accepted it; outputs are compared mid-cycle.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_reset();
                e_iready = 0;
                e_lready = 0;
                compare_all();
            end else begin
                any_req = ifu_req_valid || lsu_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
                pick_l = (ifu_req_valid && lsu_req_valid) ? !m_last_lsu : lsu_req_valid;
`else
                pick_l = lsu_req_valid;
`endif
                e_iready = !m_busy && any_req && !pick_l;
                e_lready = !m_busy && any_req && pick_l;
                compare_all();
                m_irv = 0;
                m_lrv = 0;
                if (!m_busy) begin
                    if (any_req) begin
                        m_busy = 1; m_owner_lsu = pick_l; m_last_lsu = pick_l;
                        m_age = 0; m_acc = 0;
                        if (pick_l) begin
                            m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                        end else begin
                            m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                        end
                    end
                end else begin
                    m_age++;
                    if (m_acc && mem_resp_valid)
                        deliver(mem_resp_err, (m_owner_lsu && m_wen) ? 32'h0 : mem_rdata);
                    else if (TO > 0 && m_age == TO)
                        deliver(1'b1, 32'h0);
                    else if (mem_req_ready)
                        m_acc = 1;
                end
            end
        end
    end

    int t0, at, ng, cnt;
    logic [1:0] grants [3];
    logic [1:0] exp_g  [3];

    initial begin
        rst = 0;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1;
        repeat (3) tick();
        rst = 1;
        tick();

        // lone IFU fetch, zero-wait memory
        mem_data = 32'h0000_0413;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        chk("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
        t0 = cyc;
        tick();
        ifu_req_valid = 0;
        @(negedge clk);
        chk("t1_mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_mem_wen", 32'(mem_wen), 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        wait_resp(0, 10, at);
        chk("t1_latency", 32'(at - t0), 32'd3);
        chk("t1_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_err", 32'(ifu_resp_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // LSU store with 4 stall cycles on mem_req_ready
        tick();
        mem_data = 32'h1234_5678;
        mem_req_ready = 0;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clk);
        chk("t2_lsu_ready", 32'(lsu_req_ready), 32'd1);
        tick();
        lsu_req_valid = 0; lsu_wdata = '0; lsu_addr = '0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            chk("t2_stall_valid", 32'(mem_req_valid), 32'd1);
            chk("t2_stall_addr", mem_addr, 32'h8000_1000);
            chk("t2_stall_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("t2_stall_wmask", 32'(mem_wmask), 32'hF);
            chk("t2_stall_wen", 32'(mem_wen), 32'd1);
            tick();
        end
        mem_req_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(ifu_resp_valid);
            if (lsu_resp_valid) break;
        end
        chk("t2_lsu_resp", 32'(lsu_resp_valid), 32'd1);
        chk("t2_err", 32'(lsu_resp_err), 32'd0);
        chk("t2_rdata", lsu_rdata, 32'h0);
        chk("t2_no_ifu_resp", 32'(cnt), 32'd0);

        // contention, three back-to-back grants from reset
        tick();
        rst = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        mem_data = 32'h0BAD_F00D;
        lsu_wen = 0; lsu_wmask = '0; lsu_addr = 32'h8000_3000;
        ifu_addr = 32'h8000_0100;
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int i = 0; i < 3; i++) grants[i] = 2'd2;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'd1; exp_g[1] = 2'd0; exp_g[2] = 2'd1;
`else
        exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1;
`endif
        ng = 0;
        for (int i = 0; i < 40 && ng < 3; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin
                grants[ng] = 2'd1; ng++;
            end else if (ifu_req_ready) begin
                grants[ng] = 2'd0; ng++;
            end
            tick();
            if (ng == 3) begin
                ifu_req_valid = 0; lsu_req_valid = 0;
            end
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        chk("t3_grant_count", 32'(ng), 32'd3);
        for (int i = 0; i < 3; i++) chk("t3_grant_order", 32'(grants[i]), 32'(exp_g[i]));
        repeat (6) tick();

        // watchdog: memory accepts but never answers
        mem_mute = 1;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        @(negedge clk);
        chk("t4_ifu_ready", 32'(ifu_req_ready), 32'd1);
        t0 = cyc;
        tick();
        ifu_req_valid = 0;
        wait_resp(0, 20, at);
        // the transaction owns TO busy cycles; the pulse follows the last of them
        chk("t4_latency", 32'(at - t0), 32'(TO + 1));
        chk("t4_err", 32'(ifu_resp_err), 32'd1);
        chk("t4_rdata", ifu_rdata, 32'h0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        spur = 1;
        tick();
        spur = 0;
        mem_mute = 0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += int'(ifu_resp_valid) + int'(lsu_resp_valid);
        end
        chk("t4_spurious_fwd", 32'(cnt), 32'd0);

        // reset while waiting in RESP
        tick();
        mem_mute = 1;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_5000;
        @(negedge clk);
        chk("t5_lsu_ready", 32'(lsu_req_ready), 32'd1);
        tick();
        lsu_req_valid = 0;
        tick();
        rst = 0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("t5_rst_mem_addr", mem_addr, 32'h0);
        chk("t5_rst_ifu_rdata", ifu_rdata, 32'h0);
        tick();
        tick();
        mem_mute = 0;
        rst = 1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(ifu_resp_valid) + int'(lsu_resp_valid);
        end
        chk("t5_no_aborted_resp", 32'(cnt), 32'd0);
        tick();
        mem_data = 32'hCAFE_F00D;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
        @(negedge clk);
        chk("t5_new_ready", 32'(lsu_req_ready), 32'd1);
        tick();
        lsu_req_valid = 0;
        wait_resp(1, 10, at);
        chk("t5_new_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("t5_new_err", 32'(lsu_resp_err), 32'd0);

        // memory bus error on an LSU load
        tick();
        mem_err_knob = 1;
        mem_data = 32'h0000_00EE;
        lsu_req_valid = 1; lsu_addr = 32'h8000_4000;
        tick();
        lsu_req_valid = 0;
        wait_resp(1, 10, at);
        chk("t6_err", 32'(lsu_resp_err), 32'd1);
        mem_err_knob = 0;

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
